// File: rtl/ap_arbiter_if.sv
// ap_arbiter_if: request/grant bundle between the four requesters and the
// AP selector arbiter. The requester side drives req/setN and observes the
// grant; the arbiter side owns gnt, ap_set, busy and timeout.
interface ap_arbiter_if;

  logic [3:0] req;
  logic [3:0] set0;
  logic [3:0] set1;
  logic [3:0] set2;
  logic [3:0] set3;
  logic [3:0] gnt;
  logic [3:0] ap_set;
  logic       busy;
  logic       timeout;

  // Requester side: raises requests and presents the wanted AP codes.
  modport master (
    output req, set0, set1, set2, set3,
    input  gnt, ap_set, busy, timeout
  );

  // Arbiter side: samples requests and drives the registered grant outputs.
  modport slave (
    input  req, set0, set1, set2, set3,
    output gnt, ap_set, busy, timeout
  );

endinterface

// File: rtl/ap_arbiter.sv
// ap_arbiter: four-way round-robin arbiter for the AP selector.
// A winner holds the selector until it drops its request; while it holds it,
// its AP code is registered onto ap_set every cycle. Each release is followed
// by one GAP cycle with all outputs low before the next arbitration.
// Optional feature macro AP_ARB_TIMEOUT_EN: forces a release after HOLD_MAX
// consecutive GRANT cycles and pulses timeout for one cycle. Without it the
// hold counter is not built and timeout is tied low.
module ap_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  ap_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] rrPtr_q, rrPtr_d;
  logic [1:0] grantIdx_q, grantIdx_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] apSet_q, apSet_d;
  logic       busy_q, busy_d;

  logic [1:0] winIdx;
  logic       winValid;
  logic [3:0] winCode;
  logic [3:0] ownerCode;
  logic       ownerReq;
  logic       holdExpired;

`ifdef AP_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] holdCnt_q, holdCnt_d;
  logic       timeout_q, timeout_d;

  assign holdExpired = (holdCnt_q == HOLD_LAST);
`else
  assign holdExpired = 1'b0;
`endif

  // Pick the AP code presented by a given requester in the current cycle.
  function automatic logic [3:0] codeOf(input logic [1:0] idx);
    logic [3:0] code;
    code = 4'd0;
    case (idx)
      2'd0:    code = bus.set0;
      2'd1:    code = bus.set1;
      2'd2:    code = bus.set2;
      default: code = bus.set3;
    endcase
    return code;
  endfunction

  // Round-robin search: scan from the highest offset down so the requester
  // closest to rrPtr (wrapping 3->0) is the last one written and wins.
  always_comb begin
    winIdx = rrPtr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[rrPtr_q + 2'(k)]) begin
        winIdx = rrPtr_q + 2'(k);
      end
    end
  end

  assign winValid  = |bus.req;
  assign winCode   = codeOf(winIdx);
  assign ownerCode = codeOf(grantIdx_q);
  assign ownerReq  = bus.req[grantIdx_q];

  // Next-state and registered-output logic: grant on the arbitration edge,
  // track the owner's code while it keeps requesting, release into GAP.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    grantIdx_d = grantIdx_q;
    gnt_d      = gnt_q;
    apSet_d    = apSet_q;
    busy_d     = busy_q;
`ifdef AP_ARB_TIMEOUT_EN
    holdCnt_d  = holdCnt_q;
    timeout_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        gnt_d   = 4'd0;
        apSet_d = 4'd0;
        busy_d  = 1'b0;
        if (winValid) begin
          state_d    = GRANT;
          grantIdx_d = winIdx;
          gnt_d      = 4'b0001 << winIdx;
          apSet_d    = winCode;
          busy_d     = 1'b1;
`ifdef AP_ARB_TIMEOUT_EN
          holdCnt_d  = 8'd0;
`endif
        end
      end

      GRANT: begin
`ifdef AP_ARB_TIMEOUT_EN
        holdCnt_d = holdCnt_q + 8'd1;
`endif
        if (!ownerReq || holdExpired) begin
          state_d = GAP;
          gnt_d   = 4'd0;
          apSet_d = 4'd0;
          busy_d  = 1'b0;
          rrPtr_d = grantIdx_q + 2'd1;
`ifdef AP_ARB_TIMEOUT_EN
          timeout_d = ownerReq;
`endif
        end else begin
          apSet_d = ownerCode;
        end
      end

      GAP: begin
        state_d = IDLE;
        gnt_d   = 4'd0;
        apSet_d = 4'd0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'd0;
        apSet_d = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant at once with no GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= 2'd0;
      grantIdx_q <= 2'd0;
      gnt_q      <= 4'd0;
      apSet_q    <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grantIdx_q <= grantIdx_d;
      gnt_q      <= gnt_d;
      apSet_q    <= apSet_d;
      busy_q     <= busy_d;
    end
  end

`ifdef AP_ARB_TIMEOUT_EN
  // Hold counter and forced-release pulse, only present with the timeout build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdCnt_q <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt    = gnt_q;
  assign bus.ap_set = apSet_q;
  assign bus.busy   = busy_q;

`ifndef SYNTHESIS
  // HOLD_MAX must fit the 8-bit hold counter and allow at least one cycle.
  a_holdRange: assert property (@(posedge clk) (HOLD_MAX >= 1) && (HOLD_MAX <= 255));

  // Grant is never more than one-hot.
  a_gntOneHot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

  // busy is high exactly when someone holds the selector.
  a_busyGnt: assert property (@(posedge clk) disable iff (!rst_n) busy_q == (gnt_q != 4'd0));
`endif

endmodule

// File: tb/tb_ap_arbiter.sv
// tb_ap_arbiter: directed bench for ap_arbiter with a cycle model of the
// arbitration rules. Builds with or without AP_ARB_TIMEOUT_EN; HOLD_MAX = 4.
module tb_ap_arbiter;

  localparam int HOLD = 4;
  localparam int CLK_HALF = 5;
`ifdef AP_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  ap_arbiter_if bus ();

  ap_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end

  // Model state: who owns the selector (-1 = nobody), whether the next cycle
  // is the post-release gap, where the next search starts, and how many
  // GRANT cycles the current owner has had so far.
  int         mOwner = -1;
  bit         mGap   = 1'b0;
  int         mPtr   = 0;
  int         mHeld  = 0;
  logic [3:0] mAp    = 4'd0;
  logic       mTo    = 1'b0;

  function automatic logic [3:0] setOf(input int i);
    logic [3:0] code;
    case (i)
      0:       code = bus.set0;
      1:       code = bus.set1;
      2:       code = bus.set2;
      default: code = bus.set3;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] expGnt();
    return (mOwner >= 0) ? 4'(1 << mOwner) : 4'd0;
  endfunction

  function automatic int idxOf(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model one clock using the requests seen at this edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner = -1;
      mGap   = 1'b0;
      mPtr   = 0;
      mHeld  = 0;
      mAp    = 4'd0;
      mTo    = 1'b0;
    end else begin
      mTo = 1'b0;
      if (mOwner >= 0) begin
        if (!bus.req[mOwner] || (TIMEOUT_ON && mHeld == HOLD)) begin
          mTo    = bus.req[mOwner];
          mPtr   = (mOwner + 1) % 4;
          mOwner = -1;
          mGap   = 1'b1;
          mAp    = 4'd0;
        end else begin
          mAp   = setOf(mOwner);
          mHeld = mHeld + 1;
        end
      end else if (mGap) begin
        mGap = 1'b0;
      end else if (bus.req != 4'd0) begin
        for (int k = 0; k < 4; k++) begin
          if (mOwner < 0 && bus.req[(mPtr + k) % 4]) mOwner = (mPtr + k) % 4;
        end
        mHeld = 1;
        mAp   = setOf(mOwner);
      end
    end
  end

  // One comparison: count it, and report a mismatch on one line.
  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive all requester inputs at once.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] s0, input logic [3:0] s1,
                               input logic [3:0] s2, input logic [3:0] s3);
    bus.req  = r;
    bus.set0 = s0;
    bus.set1 = s1;
    bus.set2 = s2;
    bus.set3 = s3;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Pulse reset between edges and confirm outputs are cleared immediately.
  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    #1;
    checkOutput("rst_gnt", bus.gnt, 4'd0);
    checkOutput("rst_busy", {3'd0, bus.busy}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Every falling edge outside reset, outputs must match the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("cyc_gnt", bus.gnt, expGnt());
      checkOutput("cyc_ap_set", bus.ap_set, mAp);
      checkOutput("cyc_busy", {3'd0, bus.busy}, {3'd0, (mOwner >= 0)});
      checkOutput("cyc_timeout", {3'd0, bus.timeout}, {3'd0, mTo});
    end
  end

  // Hard stop in case a scenario never completes.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Directed scenarios.
  initial begin
    int         order[5];
    int         expOrder[5] = '{0, 1, 2, 3, 0};
    int         nGrants;
    logic [3:0] prevGnt;
    int         held;
    int         pulses;
    bit         saw2;

    rst_n = 1'b1;
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("init_gnt", bus.gnt, 4'd0);
    checkOutput("init_ap_set", bus.ap_set, 4'd0);
    checkOutput("init_busy", {3'd0, bus.busy}, 4'd0);
    checkOutput("init_timeout", {3'd0, bus.timeout}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0 with code 5 for three sampled edges.
    $display("[TB] single requester");
    applyReset();
    applyStimulus(4'b0001, 4'd5, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("single_gnt", bus.gnt, 4'b0001);
    checkOutput("single_ap1", bus.ap_set, 4'd5);
    checkOutput("single_busy", {3'd0, bus.busy}, 4'd1);
    tick();
    checkOutput("single_ap2", bus.ap_set, 4'd5);
    tick();
    checkOutput("single_ap3", bus.ap_set, 4'd5);
    applyStimulus(4'b0000, 4'd5, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("single_gap_gnt", bus.gnt, 4'd0);
    checkOutput("single_gap_ap", bus.ap_set, 4'd0);
    checkOutput("single_gap_busy", {3'd0, bus.busy}, 4'd0);
    tick();
    checkOutput("single_idle_gnt", bus.gnt, 4'd0);

    // All four requesting; each gives up after two grant cycles.
    $display("[TB] round robin");
    applyReset();
    applyStimulus(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4);
    nGrants = 0;
    prevGnt = 4'd0;
    for (int cyc = 0; cyc < 60 && nGrants < 5; cyc++) begin
      tick();
      if (bus.gnt != 4'd0 && prevGnt == 4'd0) begin
        order[nGrants] = idxOf(bus.gnt);
        nGrants++;
      end
      prevGnt = bus.gnt;
      bus.req = 4'b1111;
      if (mOwner >= 0 && mHeld == 2) bus.req[mOwner] = 1'b0;
    end
    checkOutput("rr_count", 4'(nGrants), 4'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_order%0d", i), 4'(order[i]), 4'(expOrder[i]));
    end
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
    tick(3);

    // Requester 2 owns the selector; its code changes are tracked, requester 1 is ignored.
    $display("[TB] code tracking");
    applyStimulus(4'b0100, 4'd0, 4'd0, 4'd3, 4'd0);
    tick();
    checkOutput("code_gnt", bus.gnt, 4'b0100);
    checkOutput("code_ap3", bus.ap_set, 4'd3);
    applyStimulus(4'b0110, 4'd0, 4'd7, 4'd3, 4'd0);
    tick();
    checkOutput("code_nopreempt", bus.gnt, 4'b0100);
    checkOutput("code_ap3_hold", bus.ap_set, 4'd3);
    applyStimulus(4'b0110, 4'd0, 4'd2, 4'd9, 4'd0);
    tick();
    checkOutput("code_ap9", bus.ap_set, 4'd9);
    applyStimulus(4'b0110, 4'd0, 4'd15, 4'd9, 4'd0);
    tick();
    checkOutput("code_ap9_hold", bus.ap_set, 4'd9);
    checkOutput("code_gnt_hold", bus.gnt, 4'b0100);
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
    tick(3);

    // Requester 1 keeps requesting while requester 2 waits.
    $display("[TB] long hold");
    applyStimulus(4'b0110, 4'd0, 4'd4, 4'd6, 4'd0);
    held   = 0;
    pulses = 0;
    saw2   = 1'b0;
    for (int cyc = 0; cyc < (TIMEOUT_ON ? 8 : 300); cyc++) begin
      tick();
      if (bus.gnt == 4'b0010) held++;
      if (bus.timeout) pulses++;
      if (bus.gnt == 4'b0100) saw2 = 1'b1;
    end
    if (TIMEOUT_ON) begin
      checkOutput("hold_cycles", 4'(held), 4'd4);
      checkOutput("hold_pulses", 4'(pulses), 4'd1);
      checkOutput("hold_next2", {3'd0, saw2}, 4'd1);
    end else begin
      checkOutput("hold_cycles_lo", 4'(held), 4'(300 % 16));
      checkOutput("hold_cycles_hi", 4'(held / 16), 4'(300 / 16));
      checkOutput("hold_pulses", 4'(pulses), 4'd0);
      checkOutput("hold_still1", bus.gnt, 4'b0010);
      applyStimulus(4'b0100, 4'd0, 4'd4, 4'd6, 4'd0);
      saw2 = 1'b0;
      for (int cyc = 0; cyc < 10 && !saw2; cyc++) begin
        tick();
        if (bus.gnt == 4'b0100) saw2 = 1'b1;
      end
      checkOutput("hold_next2", {3'd0, saw2}, 4'd1);
      checkOutput("hold_next2_ap", bus.ap_set, 4'd6);
    end
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
    tick(4);

    // Reset arrives while requester 3 holds code 12.
    $display("[TB] reset mid grant");
    applyStimulus(4'b1000, 4'd0, 4'd0, 4'd0, 4'd12);
    tick();
    checkOutput("rst_pre_gnt", bus.gnt, 4'b1000);
    checkOutput("rst_pre_ap", bus.ap_set, 4'd12);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_gnt", bus.gnt, 4'd0);
    checkOutput("rst_mid_ap", bus.ap_set, 4'd0);
    checkOutput("rst_mid_busy", {3'd0, bus.busy}, 4'd0);
    checkOutput("rst_mid_timeout", {3'd0, bus.timeout}, 4'd0);
    #1 rst_n = 1'b1;
    applyStimulus(4'b1001, 4'd0, 4'd0, 4'd0, 4'd12);
    tick();
    checkOutput("rst_post_gnt", bus.gnt, 4'b0001);
    checkOutput("rst_post_ap0", bus.ap_set, 4'd0);
    checkOutput("rst_post_busy", {3'd0, bus.busy}, 4'd1);
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ap_arbiter.md
AP_ARBITER -- requirements
Module: ap_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16, maximum consecutive GRANT cycles per grant; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request; bit i = requester i.
REQ-005 set0, set1, set2, set3  input  4 each  requested AP code of requester i; 0 = no-op, 1..15 select AP 0..14.
REQ-006 gnt  output  4  registered one-hot grant, all-zero when nobody holds the AP selector.
REQ-007 ap_set  output  4  registered AP code driven to the AP select stage.
REQ-008 busy  output  1  registered; high while state is GRANT.
REQ-009 timeout  output  1  registered single-cycle pulse on forced release.

Function
REQ-010 The arbiter SHALL have three states: IDLE, GRANT and GAP.
REQ-011 IDLE: if req != 0, the arbiter SHALL select the first asserted bit searching upward from rr_ptr with wrap 3->0, and SHALL enter GRANT with gnt one-hot to the winner on the same edge.
REQ-012 IDLE with req == 0 SHALL stay in IDLE with gnt = 0, ap_set = 0, busy = 0.
REQ-013 Latency: req sampled high at edge k SHALL give gnt/busy high after edge k, with no other requester holding the selector.
REQ-014 GRANT: every edge with req[g] high (g = granted index) SHALL load ap_set from set_g of that cycle, so code changes reach ap_set one cycle later.
REQ-015 GRANT: the edge that first samples req[g] low SHALL clear gnt, busy and ap_set to 0, set rr_ptr = (g+1) mod 4, and enter GAP.
REQ-016 GAP SHALL last exactly one cycle with all outputs 0 and then enter IDLE unconditionally; requests during GAP are arbitrated in the following IDLE cycle.
REQ-017 An 8-bit hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle.
REQ-018 Requests from non-granted requesters SHALL be ignored during GRANT; no preemption.
REQ-019 A requester that is still requesting after release SHALL be re-granted only through normal round-robin order, so a lone requester wins again.
REQ-020 Every set code 0..15 SHALL be granted normally; code 0 only drives ap_set = 0 (no-op).
REQ-021 gnt SHALL never have more than one bit set.

Reset
REQ-022 rst_n low SHALL immediately, without a clock, force state IDLE, gnt = 0, ap_set = 0, busy = 0, timeout = 0, rr_ptr = 0 and hold counter = 0.
REQ-023 Reset asserted mid-GRANT SHALL abort the grant with no GAP cycle; after release the first arbitration starts from requester 0.

Configuration
REQ-024 Macro AP_ARB_TIMEOUT_EN, when defined, SHALL enable the forced release: in GRANT, when the hold counter equals HOLD_MAX-1 and req[g] is still high, the next edge SHALL release exactly as in REQ-015 and pulse timeout high for one cycle.
REQ-025 Without AP_ARB_TIMEOUT_EN the grant SHALL be held until req[g] drops, the hold counter logic SHALL be absent, and timeout SHALL be tied to 0.

Verification
REQ-026 Single requester: req = 0001 with set0 = 5 for 3 cycles, then 0 -> gnt = 0001 one cycle after req; ap_set = 5 for 3 cycles; then one GAP cycle at 0; then IDLE.
REQ-027 Round-robin: req = 1111 held, each requester drops req after 2 grant cycles then reasserts -> grant order 0,1,2,3,0 with one GAP cycle between grants.
REQ-028 Code tracking: requester 2 granted, set2 changes 3 -> 9 -> ap_set follows one cycle later; set1 toggling while not granted leaves ap_set unchanged.
REQ-029 Timeout (macro defined, HOLD_MAX = 4): requester 1 holds req high -> release after 4 GRANT cycles, timeout pulses once; with req = 0110 next grant goes to requester 2.
REQ-030 Timeout (macro undefined): the same stimulus as REQ-029 -> grant held for 300 cycles and timeout stays 0.
REQ-031 Reset mid-grant: requester 3 granted with ap_set = 12, rst_n pulsed low between edges -> all outputs 0 immediately; after release with req = 1001, requester 0 wins.
